alrd_mux_rr: RTL and testbench

- Registered N:1 multiplexer for AL read channels; the successor of the combinational priority AL read mux.
- Adds round-robin or fixed-priority arbitration, a registered AR output stage, per-slave outstanding-read limiting, and detection of illegal responses.
- Sits between N AL read masters (slaves of this block) and one shared AL read target. The R channel is routed back by ID.

---
 rtl/alrd_mux_rr_pkg.sv | 12 +
 rtl/alrd_rr_arb.sv | 46 ++++
 rtl/alrd_mux_rr.sv | 121 ++++++++++++
 tb/tb_alrd_mux_rr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alrd_mux_rr_pkg.sv
// alrd_mux_rr_pkg: width helpers shared by the alrd_* read-mux blocks.
package alrd_mux_rr_pkg;

    function automatic int al_word_w(input int addr_w, input int data_bits);
        return addr_w - data_bits;
    endfunction

    function automatic int al_id_w_fix(input int id_bits);
        return (id_bits > 1) ? id_bits : 1;
    endfunction

endpackage

// File: rtl/alrd_rr_arb.sv
// alrd_rr_arb: round-robin / fixed-priority grant among eligible slaves.
module alrd_rr_arb #(
    parameter int SLAVE_COUNT = 4,
    parameter int ARB_RR      = 1,
    parameter int IDW         = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SLAVE_COUNT-1:0] elig_i,
    input  logic                   adv_i,
    output logic [IDW-1:0]         grant_o,
    output logic                   any_o
);

    logic [IDW-1:0] ptr_q, ptr_d, base, g_lo, g_hi;
    logic           hit_hi;

    assign base = (ARB_RR != 0) ? ptr_q : '0;

    // Descending scan leaves the lowest eligible index at or above base in g_hi,
    // and the lowest eligible index overall in g_lo for the wrap-around case.
    always_comb begin
        g_lo   = '0;
        g_hi   = '0;
        hit_hi = 1'b0;
        for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                g_lo = IDW'(i);
                if (IDW'(i) >= base) begin
                    g_hi   = IDW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
    end

    assign grant_o = hit_hi ? g_hi : g_lo;
    assign any_o   = |elig_i;
    assign ptr_d   = (grant_o == IDW'(SLAVE_COUNT - 1)) ? '0 : grant_o + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else if (adv_i) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alrd_mux_rr.sv
// alrd_mux_rr: registered N:1 AL read mux with arbitration, outstanding limiting
// and illegal-response detection; R beats are routed back by ID.
module alrd_mux_rr
    import alrd_mux_rr_pkg::*;
#(
    parameter int DATA_BITS            = 2,
    parameter int DATA_WIDTH           = 8 << DATA_BITS,
    parameter int ADDR_WIDTH           = 4,
    parameter int SLAVE_COUNT          = 4,
    parameter int SLAVE_COUNT_BITS     = $clog2(SLAVE_COUNT),
    parameter int SLAVE_COUNT_BITS_FIX = al_id_w_fix(SLAVE_COUNT_BITS),
    parameter int MAX_OUTSTANDING      = 4,
    parameter int ARB_RR               = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [SLAVE_COUNT*(ADDR_WIDTH-DATA_BITS)-1:0]  sn_al_araddr,
    input  logic [SLAVE_COUNT-1:0]                         sn_al_arvalid,
    output logic [SLAVE_COUNT-1:0]                         sn_al_arready,
    output logic [SLAVE_COUNT*DATA_WIDTH-1:0]              sn_al_rdata,
    output logic [SLAVE_COUNT-1:0]                         sn_al_rvalid,
    input  logic [SLAVE_COUNT-1:0]                         sn_al_rready,
    output logic [ADDR_WIDTH-DATA_BITS-1:0]                m_al_araddr,
    output logic                                           m_al_arvalid,
    output logic [SLAVE_COUNT_BITS_FIX-1:0]                m_al_arid,
    input  logic                                           m_al_arready,
    input  logic [DATA_WIDTH-1:0]                          m_al_rdata,
    input  logic                                           m_al_rvalid,
    input  logic [SLAVE_COUNT_BITS_FIX-1:0]                m_al_rid,
    output logic                                           m_al_rready,
    output logic                                           err_rid
);

    localparam int AW  = al_word_w(ADDR_WIDTH, DATA_BITS);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDW = SLAVE_COUNT_BITS_FIX;

    logic [SLAVE_COUNT-1:0] elig, rid_hit, cnt_nz, dec;
    logic [CW-1:0]          cnt_q [SLAVE_COUNT];
    logic [CW-1:0]          cnt_d [SLAVE_COUNT];
    logic [IDW-1:0]         grant, arid_q;
    logic [AW-1:0]          araddr_q, addr_sel;
    logic                   arvalid_q, err_q, load, any, take, legal;

    always_comb begin
        elig     = '0;
        rid_hit  = '0;
        cnt_nz   = '0;
        addr_sel = '0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            elig[i]    = sn_al_arvalid[i] & (cnt_q[i] < CW'(MAX_OUTSTANDING));
            rid_hit[i] = (m_al_rid == IDW'(i));
            cnt_nz[i]  = (cnt_q[i] != '0);
            if (grant == IDW'(i)) addr_sel = sn_al_araddr[i*AW +: AW];
        end
    end

    generate
        if (SLAVE_COUNT == 1) begin : g_single
            assign grant = '0;
            assign any   = elig[0];
        end else begin : g_arb
            alrd_rr_arb #(
                .SLAVE_COUNT (SLAVE_COUNT),
                .ARB_RR      (ARB_RR),
                .IDW         (IDW)
            ) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .elig_i  (elig),
                .adv_i   (take),
                .grant_o (grant),
                .any_o   (any)
            );
        end
    endgenerate

    assign load          = ~arvalid_q | m_al_arready;
    assign take          = load & any;
    assign sn_al_arready = take ? (SLAVE_COUNT'(1) << grant) : '0;

    // An out-of-range ID matches no rid_hit bit, so it is illegal like a zero-count hit.
    assign legal        = |(rid_hit & cnt_nz);
    assign m_al_rready  = legal ? |(rid_hit & sn_al_rready) : 1'b1;
    assign sn_al_rvalid = (m_al_rvalid & legal) ? rid_hit : '0;
    assign dec          = (m_al_rvalid & legal & m_al_rready) ? rid_hit : '0;
    assign sn_al_rdata  = {SLAVE_COUNT{m_al_rdata}};

    always_comb begin
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            cnt_d[i] = (sn_al_arready[i] & ~dec[i]) ? cnt_q[i] + 1'b1 :
                       (dec[i] & ~sn_al_arready[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < SLAVE_COUNT; i++) cnt_q[i] <= '0;
        end else begin
            if (take) begin
                arvalid_q <= 1'b1;
                araddr_q  <= addr_sel;
                arid_q    <= grant;
            end else if (load) begin
                arvalid_q <= 1'b0;
            end
            err_q <= err_q | (m_al_rvalid & ~legal);
            for (int i = 0; i < SLAVE_COUNT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign m_al_arvalid = arvalid_q;
    assign m_al_araddr  = araddr_q;
    assign m_al_arid    = arid_q;
    assign err_rid      = err_q;

endmodule

// File: tb/tb_alrd_mux_rr.sv
// tb_alrd_mux_rr: directed vector table plus hand sequences for alrd_mux_rr.
module tb_alrd_mux_rr;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   sn_al_araddr = 8'h39;
    logic [3:0]   sn_al_arvalid = '0, sn_al_rready = '0;
    logic [3:0]   sn_al_arready, sn_al_rvalid, fp_arready, fp_rvalid;
    logic [127:0] sn_al_rdata, fp_rdata;
    logic [1:0]   m_al_araddr, m_al_arid, m_al_rid = '0, fp_araddr, fp_arid;
    logic         m_al_arvalid, m_al_arready = 1'b0, m_al_rvalid = 1'b0, m_al_rready, err_rid;
    logic         fp_arvalid, fp_rready, fp_err;
    logic [31:0]  m_al_rdata = 32'hDEADBEEF;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alrd_mux_rr dut (
        .clk(clk), .rst_n(rst_n),
        .sn_al_araddr(sn_al_araddr), .sn_al_arvalid(sn_al_arvalid), .sn_al_arready(sn_al_arready),
        .sn_al_rdata(sn_al_rdata), .sn_al_rvalid(sn_al_rvalid), .sn_al_rready(sn_al_rready),
        .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid), .m_al_arid(m_al_arid),
        .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
        .m_al_rid(m_al_rid), .m_al_rready(m_al_rready), .err_rid(err_rid)
    );

    alrd_mux_rr #(.ARB_RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .sn_al_araddr(sn_al_araddr), .sn_al_arvalid(sn_al_arvalid), .sn_al_arready(fp_arready),
        .sn_al_rdata(fp_rdata), .sn_al_rvalid(fp_rvalid), .sn_al_rready(sn_al_rready),
        .m_al_araddr(fp_araddr), .m_al_arvalid(fp_arvalid), .m_al_arid(fp_arid),
        .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
        .m_al_rid(m_al_rid), .m_al_rready(fp_rready), .err_rid(fp_err)
    );

    typedef struct {
        logic       rst;
        logic [3:0] arv;
        logic       ard;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] rrdy;
        logic [3:0] e_arr;
        logic [3:0] e_rv;
        logic       e_rrdy;
        logic       e_v;
        logic [1:0] e_id;
        logic [1:0] e_addr;
        logic       e_err;
    } vec_t;

    vec_t tv [20];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drv(input logic [3:0] arv, input logic ard, input logic rv,
                       input logic [1:0] rid, input logic [3:0] rrdy);
        sn_al_arvalid = arv;
        m_al_arready  = ard;
        m_al_rvalid   = rv;
        m_al_rid      = rid;
        sn_al_rready  = rrdy;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Slave word addresses: s0=1, s1=2, s2=3, s3=0.
        tv[0]  = '{0, 4'b0100, 1, 0, 0, 4'hF, 4'b0100, 4'b0000, 1, 0, 0, 0, 0};
        tv[1]  = '{0, 4'b0000, 1, 0, 0, 4'hF, 4'b0000, 4'b0000, 1, 1, 2, 3, 0};
        tv[2]  = '{0, 4'b0000, 1, 1, 2, 4'hF, 4'b0000, 4'b0100, 1, 0, 2, 3, 0};
        tv[3]  = '{1, 4'b0000, 0, 0, 0, 4'hF, 4'b0000, 4'b0000, 1, 0, 0, 0, 0};
        tv[4]  = '{0, 4'b1111, 1, 0, 0, 4'hF, 4'b0001, 4'b0000, 1, 0, 0, 0, 0};
        tv[5]  = '{0, 4'b1111, 1, 0, 0, 4'hF, 4'b0010, 4'b0000, 1, 1, 0, 1, 0};
        tv[6]  = '{0, 4'b1111, 1, 0, 0, 4'hF, 4'b0100, 4'b0000, 1, 1, 1, 2, 0};
        tv[7]  = '{0, 4'b1111, 1, 0, 0, 4'hF, 4'b1000, 4'b0000, 1, 1, 2, 3, 0};
        tv[8]  = '{0, 4'b1111, 1, 0, 0, 4'hF, 4'b0001, 4'b0000, 1, 1, 3, 0, 0};
        for (int i = 9; i < 14; i++)
            tv[i] = '{0, 4'b1111, 0, 0, 0, 4'hF, 4'b0000, 4'b0000, 1, 1, 0, 1, 0};
        tv[14] = '{0, 4'b1111, 1, 0, 0, 4'hF, 4'b0010, 4'b0000, 1, 1, 0, 1, 0};
        tv[15] = '{0, 4'b0000, 1, 0, 0, 4'hF, 4'b0000, 4'b0000, 1, 1, 1, 2, 0};
        tv[16] = '{0, 4'b0000, 1, 0, 0, 4'hF, 4'b0000, 4'b0000, 1, 0, 1, 2, 0};
        tv[17] = '{0, 4'b0000, 1, 1, 3, 4'h7, 4'b0000, 4'b1000, 0, 0, 1, 2, 0};
        tv[18] = '{0, 4'b0000, 1, 1, 3, 4'hF, 4'b0000, 4'b1000, 1, 0, 1, 2, 0};
        tv[19] = '{0, 4'b0000, 1, 0, 0, 4'hF, 4'b0000, 4'b0000, 1, 0, 1, 2, 0};

        @(negedge clk);
        chk("reset arvalid", m_al_arvalid, 1'b0);
        chk("reset arid", m_al_arid, 2'd0);
        chk("reset araddr", m_al_araddr, 2'd0);
        chk("reset err", err_rid, 1'b0);
        chk("reset arready", sn_al_arready, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            rst_n = ~tv[i].rst;
            drv(tv[i].arv, tv[i].ard, tv[i].rv, tv[i].rid, tv[i].rrdy);
            chk($sformatf("v%0d arready", i), sn_al_arready, tv[i].e_arr);
            chk($sformatf("v%0d rvalid", i), sn_al_rvalid, tv[i].e_rv);
            chk($sformatf("v%0d rready", i), m_al_rready, tv[i].e_rrdy);
            chk($sformatf("v%0d m_arvalid", i), m_al_arvalid, tv[i].e_v);
            chk($sformatf("v%0d m_arid", i), m_al_arid, tv[i].e_id);
            chk($sformatf("v%0d m_araddr", i), m_al_araddr, tv[i].e_addr);
            chk($sformatf("v%0d err", i), err_rid, tv[i].e_err);
            if (i == 17) chk("rdata replicated", sn_al_rdata, {4{32'hDEADBEEF}});
            @(negedge clk);
        end

        // Outstanding limit on slave 1, including simultaneous AR and R.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drv(4'b0010, 1, 0, 0, 4'hF);
            chk($sformatf("lim grant%0d", c), sn_al_arready, 4'b0010);
            @(negedge clk);
        end
        drv(4'b0011, 1, 0, 0, 4'hF);
        chk("lim 5th stalled, s0 wins", sn_al_arready, 4'b0001);
        @(negedge clk);
        drv(4'b0010, 1, 1, 1, 4'hF);
        chk("lim masked", sn_al_arready, 4'b0000);
        chk("lim rvalid", sn_al_rvalid, 4'b0010);
        chk("lim s0 on m side", m_al_arid, 2'd0);
        @(negedge clk);
        drv(4'b0010, 1, 0, 0, 4'hF);
        chk("lim reenabled", sn_al_arready, 4'b0010);
        @(negedge clk);
        drv(4'b0010, 1, 1, 1, 4'hF);
        chk("lim full again", sn_al_arready, 4'b0000);
        @(negedge clk);
        drv(4'b0010, 1, 1, 1, 4'hF);
        chk("lim ar+r arready", sn_al_arready, 4'b0010);
        chk("lim ar+r rvalid", sn_al_rvalid, 4'b0010);
        @(negedge clk);
        drv(4'b0010, 1, 0, 0, 4'hF);
        chk("lim after ar+r", sn_al_arready, 4'b0010);
        @(negedge clk);
        drv(4'b0010, 1, 0, 0, 4'hF);
        chk("lim count unchanged", sn_al_arready, 4'b0000);
        chk("lim no err", err_rid, 1'b0);
        @(negedge clk);

        // Fixed-priority instance: lowest index until its limit is hit.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drv(4'b1111, 1, 0, 0, 4'hF);
            chk($sformatf("fp grant%0d", c), fp_arready, 4'b0001);
            @(negedge clk);
        end
        drv(4'b1111, 1, 0, 0, 4'hF);
        chk("fp s0 full", fp_arready, 4'b0010);
        chk("fp arid", fp_arid, 2'd0);
        @(negedge clk);

        // Illegal response: rid=1 with nothing outstanding.
        do_reset();
        drv(4'b0000, 1, 1, 1, 4'h0);
        chk("ill rready forced", m_al_rready, 1'b1);
        chk("ill no rvalid", sn_al_rvalid, 4'b0000);
        chk("ill err not yet", err_rid, 1'b0);
        @(negedge clk);
        drv(4'b0000, 1, 0, 0, 4'hF);
        chk("ill err set", err_rid, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("ill err sticky", err_rid, 1'b1);
        do_reset();
        #1;
        chk("ill err cleared", err_rid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
